// File: rtl/dec_parity_16bit.sv
// SECDED decoder for the 16-bit codeword of the 11-bit data encoder.
// Two-stage valid/ready pipeline with full backpressure and saturating error counters.
module dec_parity_16bit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      code_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [10:0]      data_out,
  output logic             err_single,
  output logic             err_double,
  output logic [4:0]       err_pos,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  // Row i lists the data bits covered by parity p_i.
  localparam logic [4:0][10:0] HMASK = {11'h6D5, 11'h5B3, 11'h38F, 11'h07F, 11'h769};

  function automatic logic [4:0] hcol(int j);
    logic [4:0] c;
    for (int k = 0; k < 5; k++) c[k] = HMASK[k][j];
    return c;
  endfunction

  logic [2:1]       vld_pipe_q;
  logic [15:0]      code_q;
  logic [10:0]      data_q, data_d;
  logic             sgl_q, sgl_d, dbl_q, dbl_d;
  logic [4:0]       pos_q, pos_d;
  logic [4:0]       syn;
  logic [CNT_W-1:0] cs_q, cd_q;
  logic             adv1, adv2, out_hs;

  assign adv2     = !vld_pipe_q[2] || out_ready;
  assign adv1     = adv2 || !vld_pipe_q[1];
  assign in_ready = adv1;
  assign out_hs   = vld_pipe_q[2] && out_ready;

  always_comb begin
    for (int i = 0; i < 5; i++) syn[i] = code_q[11+i] ^ (^(code_q[10:0] & HMASK[i]));
  end

  // Odd-weight syndromes are single errors; nonzero even ones are uncorrectable.
  always_comb begin
    data_d = code_q[10:0];
    sgl_d  = 1'b0;
    dbl_d  = 1'b0;
    pos_d  = 5'd0;
    if (^syn) begin
      sgl_d = 1'b1;
      for (int j = 0; j < 11; j++) begin
        if (syn == hcol(j)) begin
          data_d[j] = ~code_q[j];
          pos_d     = 5'(j + 1);
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (syn == 5'(1 << i)) pos_d = 5'(16 + i);
      end
    end else if (syn != 5'd0) begin
      dbl_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      code_q     <= '0;
      data_q     <= '0;
      sgl_q      <= 1'b0;
      dbl_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      if (adv1) begin
        vld_pipe_q[1] <= in_valid;
        if (in_valid) code_q <= code_in;
      end
      if (adv2) begin
        vld_pipe_q[2] <= vld_pipe_q[1];
        if (vld_pipe_q[1]) begin
          data_q <= data_d;
          sgl_q  <= sgl_d;
          dbl_q  <= dbl_d;
          pos_q  <= pos_d;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q <= '0;
      cd_q <= '0;
    end else if (cnt_clr) begin
      cs_q <= '0;
      cd_q <= '0;
    end else if (out_hs) begin
      if (sgl_q && cs_q != '1) cs_q <= cs_q + 1'b1;
      if (dbl_q && cd_q != '1) cd_q <= cd_q + 1'b1;
    end
  end

  assign out_valid  = vld_pipe_q[2];
  assign data_out   = data_q;
  assign err_single = sgl_q;
  assign err_double = dbl_q;
  assign err_pos    = pos_q;
  assign cnt_single = cs_q;
  assign cnt_double = cd_q;

endmodule
